dac_fifo_player: RTL and testbench
==================================

# dac_fifo_player

Buffered sample scheduler for the 8-bit DAC sound path. The CPU pushes samples through an I/O port into a small FIFO, and a programmable rate timer pops them at a fixed sample period onto registered left/right sample outputs. These outputs feed the existing DAC mixing stage in place of direct port latches, so sample playback no longer depends on CPU timing loops. The block sits on the CPU I/O bus alongside the other sound peripherals.

## Interface
- DEPTH, 16, FIFO entries (power of two, ≥4)
- PRESCALE, 64, clk cycles per rate-counter step
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- a  in  16  CPU address bus (only a[7:0] decoded)
- iorq_n  in  1  CPU I/O request, active low
- wr_n  in  1  CPU write strobe, active low
- rd_n  in  1  CPU read strobe, active low
- d  in  8  CPU write data
- dout  out  8  status read data
- oe  out  1  high while dout is driving a status read
- sample_l  out  8  left sample, offset binary
- sample_r  out  8  right sample, offset binary
- sample_stb  out  1  one-cycle pulse when sample_l/r update
- irq_half  out  1  high while enabled and count < DEPTH/2 (refill request)

## Operation
- Ports (a[7:0]): 0xB3 data push (W); 0xB7 control (W) and status (R); 0xBB rate (W).
- Write detect: a write cycle is `!iorq_n && !wr_n && port match`. Act only on the first clk of the cycle, using a registered previous-strobe compare. One push per CPU write, regardless of strobe length.
- Control bits:
  - bit0 enable
  - bit1 stereo
  - bit2 flush: self-clearing; zeroes pointers and count
  - bit3 clear sticky flags: self-clearing
  - Bits 0 and 1 are stored.
- Status read: `{count[4:0] saturated to 31, overflow, underrun, full}`, bits 7..3, 2, 1, 0. It is combinational. oe is asserted only during `!iorq_n && !rd_n && a[7:0]==0xB7`.
- Rate: an 8-bit register R. The tick period is (R+1)×PRESCALE clk. The prescaler and rate counters restart when R is written or enable rises.
- FIFO: 8-bit entries, wr_ptr and rd_ptr wrap modulo DEPTH, count ranges 0..DEPTH.
  - Push when full: byte dropped, overflow set (sticky).
  - Push and pop in the same cycle: both happen, count net −1 (stereo) or 0 (mono).
- Pop width: mono pops 1 entry per tick and copies it to both channels. Stereo pops 2 entries per tick: L = the rd_ptr entry, R = the rd_ptr+1 entry.
- FSM:
  - IDLE (enable=0): no pops, outputs hold. Goes to FILL when enable=1.
  - FILL: no pops. Goes to PLAY when count ≥ DEPTH/2.
  - PLAY: on each tick, pop if count ≥ need (1 mono / 2 stereo). Otherwise set underrun (sticky), hold outputs, no sample_stb, and go to FILL.
  - From any state, enable=0 goes to IDLE.
  - Flush with enable=1 goes to FILL. Flush wins over a simultaneous push or pop.
- Changing the stereo bit mid-PLAY takes effect at the next tick.

## Timing
- Reset values:
  - sample_l = sample_r = 0x80
  - sample_stb = 0, irq_half = 0, oe = 0, dout = 0x00
  - count = 0, pointers = 0, flags = 0, R = 0, state IDLE
- A tick is a one-cycle internal pulse. sample_l/r and sample_stb are registered and update on the clk after the tick.
- A push is visible in count one clk after the first write cycle.
- Minimum tick period is PRESCALE clk (R = 0).
- irq_half is registered from count and lags count by one clk.
- Reset asserted mid-operation returns immediately to all reset values. FIFO contents are don't-care.

## Structure
- Shared sound package: the port address constants (0xB3/0xB7/0xBB), the control bit indices, and the FSM state enum.
- One sub-module, `sample_fifo`: DEPTH×8 register array, single write port, dual-entry read (rd_ptr and rd_ptr+1), pop of 1 or 2, count/full outputs.
- The top level holds the bus decode, write-edge detect, rate timer, FSM and output registers.

## Test plan
- Reset → sample_l/r = 0x80, status read = 0x00, irq_half = 0.
- Enable mono, R = 0, push 8 bytes 0x10..0x17 → enters PLAY at count 8. sample_l = sample_r = 0x10, 0x11, … on successive ticks, exactly 64 clk apart, one sample_stb each.
- Stereo, push 0xA0, 0x20 ×4 pairs and 4 more pairs → each tick gives L=0xA0, R=0x20. count drops by 2 per tick.
- Stall: drain the FIFO to 1 entry in stereo → next tick gives no strobe, outputs hold, underrun bit reads 1, state returns to FILL. Control write bit3 → underrun reads 0.
- Push 17 bytes with enable=0 → count 16, full = 1, overflow = 1. The 17th byte is never played.
- Single write held for 6 clk → count +1 only. Push coinciding with a mono tick → count unchanged. Flush coinciding with a push → count = 0.

Source files
------------

// File: rtl/dac_fifo_player_pkg.sv
// Shared definitions for the DAC sample player: I/O port map, control bit
// positions, playback state encoding and a status helper.
package dac_fifo_player_pkg;

   localparam logic [7:0] PORT_DATA = 8'hB3;
   localparam logic [7:0] PORT_CTRL = 8'hB7;
   localparam logic [7:0] PORT_RATE = 8'hBB;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_STEREO = 1;
   localparam int CTRL_FLUSH  = 2;
   localparam int CTRL_CLEAR  = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_PLAY = 2'd2
   } play_state_t;

   // Entry count squeezed into the 5-bit status field; larger depths read 31.
   function automatic logic [4:0] sat_count5(input logic [31:0] cnt);
      logic [4:0] res;
      if (cnt > 32'd31) begin
         res = 5'd31;
      end else begin
         res = cnt[4:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/dac_fifo_player_sample_fifo.sv
// Sample FIFO: DEPTH x 8 register array, one write port, two adjacent read
// entries (rd_ptr and rd_ptr+1) so a stereo pair can be popped in one cycle.
module sample_fifo #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [7:0]    wdata,
   input  logic          pop,
   input  logic          pop_two,
   output logic [7:0]    rdata0,
   output logic [7:0]    rdata1,
   output logic [CW-1:0] count,
   output logic          full
);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          push_ok_s;
   logic [CW-1:0] pop_n_s;

   assign full      = (count_r == CW'(DEPTH));
   assign count     = count_r;
   assign push_ok_s = push && !full && !flush;
   assign rdata0    = mem_r[rd_ptr_r];
   assign rdata1    = mem_r[rd_ptr_r + AW'(1)];

   // Number of entries leaving the FIFO this cycle.
   always_comb begin
      pop_n_s = CW'(0);
      if (pop && pop_two) begin
         pop_n_s = CW'(2);
      end else if (pop) begin
         pop_n_s = CW'(1);
      end else begin
         pop_n_s = CW'(0);
      end
   end

   // Storage array; contents after reset or flush are never read before rewritten.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers and occupancy; flush clears them and overrides push and pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + pop_n_s[AW-1:0];
         end
         count_r <= count_r + CW'(push_ok_s) - pop_n_s;
      end
   end

endmodule

// File: rtl/dac_fifo_player.sv
// Buffered DAC sample player: CPU pushes bytes through an I/O port, a rate
// timer pops them onto registered left/right sample outputs.
module dac_fifo_player
   import dac_fifo_player_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int PRESCALE = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic        iorq_n,
   input  logic        wr_n,
   input  logic        rd_n,
   input  logic [7:0]  d,
   output logic [7:0]  dout,
   output logic        oe,
   output logic [7:0]  sample_l,
   output logic [7:0]  sample_r,
   output logic        sample_stb,
   output logic        irq_half
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic          io_wr_s, data_sel_s, ctrl_sel_s, rate_sel_s;
   logic          data_sel_r, ctrl_sel_r, rate_sel_r;
   logic          data_push_s, ctrl_wr_s, rate_wr_s;
   logic          flush_s, clear_s, timer_restart_s;
   logic          enable_r, stereo_r, overflow_r, underrun_r;
   logic [7:0]    rate_r;
   logic [PW-1:0] presc_r;
   logic [7:0]    rate_cnt_r;
   logic          tick_s, have_s, pop_s;
   logic [7:0]    rdata0_s, rdata1_s;
   logic [CW-1:0] count_s;
   logic          full_s;
   play_state_t   state_r;
   logic [7:0]    sample_l_r, sample_r_r;
   logic          sample_stb_r, irq_half_r;
   logic          unused_addr_s;

   // Only the low address byte takes part in decoding.
   assign unused_addr_s = ^a[15:8];

   assign io_wr_s    = !iorq_n && !wr_n;
   assign data_sel_s = io_wr_s && (a[7:0] == PORT_DATA);
   assign ctrl_sel_s = io_wr_s && (a[7:0] == PORT_CTRL);
   assign rate_sel_s = io_wr_s && (a[7:0] == PORT_RATE);

   // One action per CPU write: act only on the first clk the strobe matches.
   assign data_push_s = data_sel_s && !data_sel_r;
   assign ctrl_wr_s   = ctrl_sel_s && !ctrl_sel_r;
   assign rate_wr_s   = rate_sel_s && !rate_sel_r;

   assign flush_s         = ctrl_wr_s && d[CTRL_FLUSH];
   assign clear_s         = ctrl_wr_s && d[CTRL_CLEAR];
   assign timer_restart_s = rate_wr_s || (ctrl_wr_s && d[CTRL_ENABLE] && !enable_r);

   assign tick_s = enable_r && !timer_restart_s &&
                   (presc_r == PW'(PRESCALE - 1)) && (rate_cnt_r >= rate_r);
   assign have_s = stereo_r ? (count_s >= CW'(2)) : (count_s >= CW'(1));
   assign pop_s  = enable_r && !flush_s && (state_r == ST_PLAY) && tick_s && have_s;

   sample_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush_s),
      .push    (data_push_s),
      .wdata   (d),
      .pop     (pop_s),
      .pop_two (stereo_r),
      .rdata0  (rdata0_s),
      .rdata1  (rdata1_s),
      .count   (count_s),
      .full    (full_s)
   );

   // Previous-cycle strobe match per port, for write edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_sel_r <= 1'b0;
         ctrl_sel_r <= 1'b0;
         rate_sel_r <= 1'b0;
      end else begin
         data_sel_r <= data_sel_s;
         ctrl_sel_r <= ctrl_sel_s;
         rate_sel_r <= rate_sel_s;
      end
   end

   // Stored control bits and rate register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable_r <= 1'b0;
         stereo_r <= 1'b0;
         rate_r   <= 8'h00;
      end else begin
         if (ctrl_wr_s) begin
            enable_r <= d[CTRL_ENABLE];
            stereo_r <= d[CTRL_STEREO];
         end
         if (rate_wr_s) begin
            rate_r <= d;
         end
      end
   end

   // Rate timer: PRESCALE clk per step, R+1 steps per tick; restarts on rate write or enable rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_r    <= '0;
         rate_cnt_r <= 8'h00;
      end else if (timer_restart_s || !enable_r) begin
         presc_r    <= '0;
         rate_cnt_r <= 8'h00;
      end else if (presc_r == PW'(PRESCALE - 1)) begin
         presc_r <= '0;
         if (rate_cnt_r >= rate_r) begin
            rate_cnt_r <= 8'h00;
         end else begin
            rate_cnt_r <= rate_cnt_r + 8'd1;
         end
      end else begin
         presc_r <= presc_r + PW'(1);
      end
   end

   // Sticky overflow: a push that finds the FIFO full is dropped and flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r <= 1'b0;
      end else if (clear_s) begin
         overflow_r <= 1'b0;
      end else if (data_push_s && full_s) begin
         overflow_r <= 1'b1;
      end
   end

   // Playback FSM with registered sample outputs, strobe and underrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         sample_l_r   <= 8'h80;
         sample_r_r   <= 8'h80;
         sample_stb_r <= 1'b0;
         underrun_r   <= 1'b0;
      end else begin
         sample_stb_r <= 1'b0;
         if (clear_s) begin
            underrun_r <= 1'b0;
         end
         if (!enable_r) begin
            state_r <= ST_IDLE;
         end else if (flush_s) begin
            state_r <= ST_FILL;
         end else begin
            case (state_r)
               ST_IDLE: state_r <= ST_FILL;
               ST_FILL: begin
                  if (count_s >= CW'(DEPTH / 2)) begin
                     state_r <= ST_PLAY;
                  end
               end
               ST_PLAY: begin
                  if (tick_s && have_s) begin
                     sample_l_r   <= rdata0_s;
                     sample_r_r   <= stereo_r ? rdata1_s : rdata0_s;
                     sample_stb_r <= 1'b1;
                  end else if (tick_s) begin
                     underrun_r <= 1'b1;
                     state_r    <= ST_FILL;
                  end
               end
               default: state_r <= ST_IDLE;
            endcase
         end
      end
   end

   // Refill request, registered from the occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_half_r <= 1'b0;
      end else begin
         irq_half_r <= enable_r && (count_s < CW'(DEPTH / 2));
      end
   end

   // Combinational status read on the control port.
   always_comb begin
      oe   = !iorq_n && !rd_n && (a[7:0] == PORT_CTRL);
      dout = 8'h00;
      if (oe) begin
         dout = {sat_count5(32'(count_s)), overflow_r, underrun_r, full_s};
      end else begin
         dout = 8'h00;
      end
   end

   assign sample_l   = sample_l_r;
   assign sample_r   = sample_r_r;
   assign sample_stb = sample_stb_r;
   assign irq_half   = irq_half_r;

endmodule

// File: tb/tb_dac_fifo_player.sv
// Self-checking bench for dac_fifo_player: scoreboard of expected samples
// popped on each sample_stb, plus status/timing checks.
module tb_dac_fifo_player;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a;
   logic        iorq_n, wr_n, rd_n;
   logic [7:0]  d;
   logic [7:0]  dout;
   logic        oe;
   logic [7:0]  sample_l, sample_r;
   logic        sample_stb;
   logic        irq_half;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int stb_count = 0;
   int extra_cnt = 0;
   int last_cyc  = 0;
   bit have_prev = 0;
   bit chk_period = 0;
   logic [15:0] exp_q[$];

   dac_fifo_player #(.DEPTH(16), .PRESCALE(64)) dut (
      .clk(clk), .rst(rst), .a(a), .iorq_n(iorq_n), .wr_n(wr_n), .rd_n(rd_n),
      .d(d), .dout(dout), .oe(oe), .sample_l(sample_l), .sample_r(sample_r),
      .sample_stb(sample_stb), .irq_half(irq_half)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] stat(input int cnt, input bit ov, input bit ur, input bit fl);
      logic [4:0] c;
      c = 5'(cnt);
      return {c, ov, ur, fl};
   endfunction

   // Scoreboard monitor: every strobe pops one expected {L,R} pair.
   always @(negedge clk) begin
      logic [15:0] e;
      if (!chk_period) have_prev = 0;
      if (sample_stb === 1'b1) begin
         stb_count++;
         if (exp_q.size() == 0) begin
            extra_cnt++;
         end else begin
            e = exp_q.pop_front();
            check_val("sb_left", {24'h0, sample_l}, {24'h0, e[15:8]});
            check_val("sb_right", {24'h0, sample_r}, {24'h0, e[7:0]});
         end
         if (chk_period && have_prev) check_val("tick_period", cyc - last_cyc, 64);
         have_prev = 1;
         last_cyc  = cyc;
      end
   end

   task automatic io_write(input logic [7:0] port, input logic [7:0] val, input int hold);
      @(negedge clk);
      a = {8'h00, port}; d = val; iorq_n = 1'b0; wr_n = 1'b0;
      repeat (hold) @(negedge clk);
      iorq_n = 1'b1; wr_n = 1'b1;
   endtask

   task automatic read_status(input string tag, input logic [7:0] exp);
      logic [7:0] v;
      logic       o;
      @(negedge clk);
      a = 16'h00B7; iorq_n = 1'b0; rd_n = 1'b0;
      #1;
      v = dout; o = oe;
      iorq_n = 1'b1; rd_n = 1'b1;
      check_val(tag, {24'h0, v}, {24'h0, exp});
      check_val("oe_during_read", {31'h0, o}, 32'd1);
   endtask

   task automatic read_count(output int cnt);
      @(negedge clk);
      a = 16'h00B7; iorq_n = 1'b0; rd_n = 1'b0;
      #1;
      cnt = int'(dout[7:3]);
      iorq_n = 1'b1; rd_n = 1'b1;
   endtask

   task automatic wait_stb_count(input int base, input int n, input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (stb_count - base >= n) break;
      end
      check_val(tag, stb_count - base, n);
   endtask

   task automatic wait_stb_edge(input int budget, input string tag);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (sample_stb === 1'b1) seen = 1;
      end
      check_val(tag, {31'h0, seen}, 32'd1);
   endtask

   initial begin
      int base, c0, c1, s0;
      rst = 1'b1; a = 16'h0000; d = 8'h00; iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check_val("rst_sample_l", {24'h0, sample_l}, 32'h80);
      check_val("rst_sample_r", {24'h0, sample_r}, 32'h80);
      check_val("rst_stb", {31'h0, sample_stb}, 32'd0);
      check_val("rst_irq", {31'h0, irq_half}, 32'd0);
      check_val("rst_oe", {31'h0, oe}, 32'd0);
      read_status("rst_status", 8'h00);

      // Mono playback at R=0: samples 64 clk apart
      io_write(8'hBB, 8'h00, 1);
      io_write(8'hB7, 8'h01, 1);
      @(negedge clk); @(negedge clk);
      check_val("irq_half_empty", {31'h0, irq_half}, 32'd1);
      chk_period = 1;
      base = stb_count;
      for (int i = 0; i < 8; i++) begin
         io_write(8'hB3, 8'h10 + 8'(i), 1);
         exp_q.push_back({8'h10 + 8'(i), 8'h10 + 8'(i)});
      end
      wait_stb_count(base, 8, 8 * 64 + 200, "mono_strobes");
      chk_period = 0;
      repeat (80) @(negedge clk);
      read_status("mono_underrun", stat(0, 0, 1, 0));
      io_write(8'hB7, 8'h09, 1);
      read_status("mono_clear", stat(0, 0, 0, 0));

      // Stereo pairs, count drops by 2 per tick, then stall on a lone entry
      io_write(8'hB7, 8'h07, 1);
      base = stb_count;
      for (int i = 0; i < 7; i++) begin
         io_write(8'hB3, 8'hA0, 1);
         io_write(8'hB3, 8'h20, 1);
         exp_q.push_back(16'hA020);
      end
      io_write(8'hB3, 8'h55, 1);
      for (int k = 0; k < 8; k++) begin
         if (stb_count - base >= 7) break;
         wait_stb_edge(150, "stereo_tick");
         read_count(c0);
         check_val("stereo_count", c0, 15 - 2 * (stb_count - base));
      end
      check_val("stereo_strobes", stb_count - base, 7);
      repeat (80) @(negedge clk);
      check_val("stall_no_stb", stb_count - base, 7);
      check_val("stall_hold_l", {24'h0, sample_l}, 32'hA0);
      check_val("stall_hold_r", {24'h0, sample_r}, 32'h20);
      check_val("stall_irq", {31'h0, irq_half}, 32'd1);
      read_status("stall_status", stat(1, 0, 1, 0));
      io_write(8'hB7, 8'h0B, 1);
      read_status("stall_clear", stat(1, 0, 0, 0));

      // Overflow while disabled, 17th byte dropped and never played
      io_write(8'hB7, 8'h04, 1);
      for (int i = 0; i < 17; i++) io_write(8'hB3, 8'h30 + 8'(i), 1);
      read_status("overflow_status", stat(16, 1, 0, 1));
      check_val("overflow_irq_off", {31'h0, irq_half}, 32'd0);
      for (int i = 0; i < 16; i++) exp_q.push_back({8'h30 + 8'(i), 8'h30 + 8'(i)});
      chk_period = 1;
      base = stb_count;
      io_write(8'hB7, 8'h01, 1);
      wait_stb_count(base, 16, 16 * 64 + 200, "full_strobes");
      chk_period = 0;
      repeat (100) @(negedge clk);
      check_val("no_17th", stb_count - base, 16);
      check_val("last_full", {24'h0, sample_l}, 32'h3F);

      // Long write strobe counts once
      io_write(8'hB7, 8'h0C, 1);
      io_write(8'hB3, 8'h77, 6);
      read_status("held_write", stat(1, 0, 0, 0));

      // Push coinciding with a mono tick leaves count unchanged
      io_write(8'hB7, 8'h05, 1);
      for (int i = 0; i < 9; i++) begin
         io_write(8'hB3, 8'h60 + 8'(i), 1);
         exp_q.push_back({8'h60 + 8'(i), 8'h60 + 8'(i)});
      end
      wait_stb_edge(200, "coinc_sync");
      read_count(c0);
      s0 = stb_count;
      repeat (61) @(negedge clk);
      exp_q.push_back(16'h6969);
      io_write(8'hB3, 8'h69, 1);
      read_count(c1);
      check_val("coinc_tick", stb_count - s0, 1);
      check_val("coinc_count", c1, c0);

      // Push immediately followed by flush in the same strobe
      @(negedge clk);
      a = 16'h00B3; d = 8'h70; iorq_n = 1'b0; wr_n = 1'b0;
      @(negedge clk);
      a = 16'h00B7; d = 8'h04;
      @(negedge clk);
      iorq_n = 1'b1; wr_n = 1'b1;
      read_status("flush_after_push", stat(0, 0, 0, 0));
      exp_q.delete();

      // Reset mid-operation
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("midrst_l", {24'h0, sample_l}, 32'h80);
      check_val("midrst_r", {24'h0, sample_r}, 32'h80);
      @(negedge clk);
      rst = 1'b0;
      read_status("midrst_status", 8'h00);

      check_val("sb_extra", extra_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
